// File: rtl/rr_io_arbiter_pkg.sv
// Shared types and helpers for the pad-driven round-robin arbiter.
package rr_io_arbiter_pkg;

  // Arbiter FSM: grant, then one release cycle, then back to idle for re-arbitration.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultMaxHold = 16;

  // Bits needed to index n items, never less than one so that vectors stay legal for n <= 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, n}) begin
        w = i + 1;
      end
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-bit, multi-stage synchroniser for asynchronous pad inputs; every stage clears on reset.
module pad_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Stages];

  // Shift the raw pad value through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < Stages; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < Stages; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/rr_io_arbiter.sv
// Round-robin arbiter for pad requests: synchronised inputs, bounded hold time with preemption
// when others are waiting, and a release cycle plus an idle cycle between successive owners.
module rr_io_arbiter
  import rr_io_arbiter_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned MAX_HOLD    = DefaultMaxHold,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [N-1:0]             req_i,
  output logic [N-1:0]             gnt_o,
  output logic                     busy_o,
  output logic [clog2_min1(N)-1:0] owner_o,
  output logic                     preempt_o
);

  localparam int unsigned OW = clog2_min1(N);
  localparam int unsigned CW = clog2_min1(MAX_HOLD);

  localparam logic [OW-1:0] LastInit = OW'(N - 1);
  localparam logic [CW-1:0] HoldMax  = CW'(MAX_HOLD - 1);

  // Index of the lowest set bit of v (0 when v is empty).
  function automatic logic [OW-1:0] lowest_set(input logic [N-1:0] v);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = OW'(i);
      end
    end
    return idx;
  endfunction

  // Round-robin pick: requesters above the last owner first, otherwise wrap to the lowest index.
  function automatic logic [OW-1:0] pick_winner(input logic [N-1:0] req,
                                                input logic [OW-1:0] last);
    logic [N-1:0] above;
    for (int i = 0; i < N; i++) begin
      above[i] = req[i] && (i > int'(last));
    end
    return (|above) ? lowest_set(above) : lowest_set(req);
  endfunction

  logic [N-1:0]  req_s;
  arb_state_e    state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  gnt_q;
  logic          busy_q;
  logic [OW-1:0] owner_out_q;
  logic          preempt_q;

  logic [OW-1:0] winner;
  logic [N-1:0]  winner_mask;
  logic [N-1:0]  owner_mask;
  logic          owner_req;
  logic          others_waiting;

  pad_sync #(
    .Width (N),
    .Stages(SYNC_STAGES)
  ) u_pad_sync (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .d_i  (req_i),
    .q_o  (req_s)
  );

  // Combinational winner scan and owner/competitor request decode.
  always_comb begin
    winner      = pick_winner(req_s, last_q);
    winner_mask = '0;
    owner_mask  = '0;
    for (int i = 0; i < N; i++) begin
      winner_mask[i] = (winner == OW'(i));
      owner_mask[i]  = (owner_q == OW'(i));
    end
    owner_req      = |(req_s & owner_mask);
    others_waiting = |(req_s & ~owner_mask);
  end

  // Arbiter FSM with registered outputs; a reset drops any grant on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      last_q      <= LastInit;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      owner_out_q <= '0;
      preempt_q   <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_s) begin
            state_q     <= StGrant;
            owner_q     <= winner;
            cnt_q       <= '0;
            gnt_q       <= winner_mask;
            busy_q      <= 1'b1;
            owner_out_q <= winner;
          end
        end
        StGrant: begin
          if (!owner_req) begin
            // Voluntary release takes priority over a coincident timeout.
            state_q     <= StRelease;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            owner_out_q <= '0;
          end else if ((cnt_q == HoldMax) && others_waiting) begin
            state_q     <= StRelease;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            owner_out_q <= '0;
            preempt_q   <= 1'b1;
          end else if (cnt_q != HoldMax) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StRelease: begin
          // The departing owner drops to lowest priority for the next scan.
          last_q  <= owner_q;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign preempt_o = preempt_q;

  if (N == 1) begin : g_single
    assign owner_o = '0;
  end else begin : g_multi
    assign owner_o = owner_out_q;
  end

endmodule

// File: tb/tb_rr_io_arbiter.sv
// Directed bench for rr_io_arbiter (N=3, MAX_HOLD=16, SYNC_STAGES=2).
module tb_rr_io_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       preempt;

  int n_assert;
  int n_fail;

  rr_io_arbiter #(
    .N          (3),
    .MAX_HOLD   (16),
    .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .busy_o   (busy),
    .owner_o  (owner),
    .preempt_o(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_pre);
    chk({tag, " gnt"}, 32'(gnt), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " owner"}, 32'(owner), 32'd0);
    chk({tag, " preempt"}, 32'(preempt), 32'(exp_pre));
  endtask

  // Entered right after the grant edge; leaves right after the next grant edge.
  task automatic tenure(input string tag, input logic [2:0] g, input logic [1:0] o);
    chk({tag, " start gnt"}, 32'(gnt), 32'(g));
    chk({tag, " start busy"}, 32'(busy), 32'd1);
    chk({tag, " start owner"}, 32'(owner), 32'(o));
    for (int i = 1; i < 16; i++) begin
      tick(1);
      chk({tag, " hold gnt"}, 32'(gnt), 32'(g));
      chk({tag, " hold preempt"}, 32'(preempt), 32'd0);
    end
    tick(1);
    chk_idle({tag, " release"}, 1'b1);
    tick(1);
    chk_idle({tag, " idle"}, 1'b0);
    tick(1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 3'b000;
    tick(2);
    chk_idle("reset", 1'b0);

    // Single requester: grant on the third edge counting the sampling edge.
    rst = 1'b0;
    req = 3'b001;
    tick(1);
    chk("lat e1 gnt", 32'(gnt), 32'd0);
    tick(1);
    chk("lat e2 gnt", 32'(gnt), 32'd0);
    tick(1);
    chk("lat e3 gnt", 32'(gnt), 32'b001);
    chk("lat e3 busy", 32'(busy), 32'd1);
    chk("lat e3 owner", 32'(owner), 32'd0);

    // All three requesting: 0,1,2,0 with 16-cycle tenures and preemption.
    rst = 1'b1;
    tick(1);
    chk_idle("reset2", 1'b0);
    rst = 1'b0;
    req = 3'b111;
    tick(3);
    tenure("rr0", 3'b001, 2'd0);
    tenure("rr1", 3'b010, 2'd1);
    tenure("rr2", 3'b100, 2'd2);
    chk("rr wrap gnt", 32'(gnt), 32'b001);
    chk("rr wrap owner", 32'(owner), 32'd0);

    // Owner 1 releases early with requester 2 pending.
    rst = 1'b1;
    tick(1);
    chk_idle("reset3", 1'b0);
    rst = 1'b0;
    req = 3'b110;
    tick(3);
    chk("early gnt1", 32'(gnt), 32'b010);
    chk("early owner1", 32'(owner), 32'd1);
    tick(4);
    chk("early hold5", 32'(gnt), 32'b010);
    req = 3'b100;
    tick(2);
    chk("early sync gnt", 32'(gnt), 32'b010);
    tick(1);
    chk_idle("early release", 1'b0);
    tick(1);
    chk_idle("early idle", 1'b0);
    tick(1);
    chk("early gnt2", 32'(gnt), 32'b100);
    chk("early owner2", 32'(owner), 32'd2);

    // Lone requester 2 keeps the grant well past MAX_HOLD.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("lone gnt", 32'(gnt), 32'b100);
      chk("lone preempt", 32'(preempt), 32'd0);
    end

    // Release coincides with the hold limit: no preempt pulse.
    rst = 1'b1;
    tick(1);
    chk_idle("reset4", 1'b0);
    rst = 1'b0;
    req = 3'b011;
    tick(3);
    chk("coin gnt0", 32'(gnt), 32'b001);
    tick(13);
    req = 3'b010;
    tick(2);
    chk("coin last hold", 32'(gnt), 32'b001);
    tick(1);
    chk_idle("coin release", 1'b0);
    tick(1);
    chk_idle("coin idle", 1'b0);
    tick(1);
    chk("coin gnt1", 32'(gnt), 32'b010);
    chk("coin owner1", 32'(owner), 32'd1);

    // Reset mid-grant, then requesters 1 and 2: requester 1 wins first.
    req = 3'b110;
    tick(3);
    chk("mid gnt", 32'(gnt), 32'b010);
    rst = 1'b1;
    tick(1);
    chk_idle("mid reset", 1'b0);
    rst = 1'b0;
    tick(1);
    chk_idle("post e1", 1'b0);
    tick(1);
    chk_idle("post e2", 1'b0);
    tick(1);
    chk("post gnt", 32'(gnt), 32'b010);
    chk("post owner", 32'(owner), 32'd1);
    chk("post busy", 32'(busy), 32'd1);
    chk("post preempt", 32'(preempt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
